// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, divider and vote helpers.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Clocks per oversample tick, truncated; also used by the TX side.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk o_tick every DIV clks, restartable by i_clr.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap && !i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with start validation and parity/frame error strobes.
// Define UART_RX_VOTE_EN for 3-sample majority voting around mid-bit.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
`ifdef UART_RX_VOTE_EN
    localparam int DEC_IDX = OVERSAMPLE / 2;
`else
    localparam int DEC_IDX = OVERSAMPLE / 2 - 1;
`endif

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_rx_os: CLK_FREQ too low for BAUD*OVERSAMPLE");
        end
    endgenerate

    logic                 r_rx_m, r_rx_s, r_rx_d;
    state_t               r_state, w_next;
    logic [SW-1:0]        r_scnt;
    logic [3:0]           r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_hold, r_valid, r_perr, r_ferr;
    logic                 w_fall, w_clr, w_tick, w_dec, w_bit, w_par_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    assign w_fall = r_rx_d && !r_rx_s;
    assign w_clr  = (r_state == IDLE) && w_fall;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Tick index within the current bit, zeroed on the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_scnt <= '0;
        else if (w_clr)
            r_scnt <= '0;
        else if (w_tick)
            r_scnt <= (r_scnt == SW'(OVERSAMPLE - 1)) ? '0 : r_scnt + SW'(1);
    end

    assign w_dec = w_tick && (r_scnt == SW'(DEC_IDX)) &&
                   (r_state != IDLE) && (r_state != BRK);

`ifdef UART_RX_VOTE_EN
    logic [1:0] r_vote;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vote <= 2'b11;
        else if (w_tick && r_scnt == SW'(DEC_IDX - 2))
            r_vote[0] <= r_rx_s;
        else if (w_tick && r_scnt == SW'(DEC_IDX - 1))
            r_vote[1] <= r_rx_s;
    end
    assign w_bit = maj3(r_vote[0], r_vote[1], r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    assign w_par_exp = (PARITY_MODE == PARITY_ODD) ? ~^r_shift : ^r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (w_fall) w_next = START;
            START:  if (w_dec) w_next = w_bit ? IDLE : DATA;
            DATA:   if (w_dec && r_bcnt == 4'(DATA_BITS - 1))
                        w_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            PARITY: if (w_dec) w_next = STOP;
            STOP:   if (w_dec) w_next = w_bit ? IDLE : BRK;
            BRK:    if (r_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcnt     <= '0;
            r_par_hold <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_clr) begin
                r_bcnt     <= '0;
                r_par_hold <= 1'b0;
            end
            if (w_dec) begin
                case (r_state)
                    DATA: begin
                        // Right shift with new bit at MSB leaves first bit at LSB.
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 4'd1;
                    end
                    PARITY: r_par_hold <= w_bit ^ w_par_exp;
                    STOP: begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                        r_perr  <= r_par_hold;
                        r_ferr  <= ~w_bit;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: 8N1 receiver (u_dut0) and 8E1 receiver (u_dut2) at 115200 baud, 50 MHz.
module tb_uart_rx_os;
    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       sel = 1'b0;
    logic       rx0, rx2;
    logic [7:0] d0, d2;
    logic       dv0, pe0, fe0, bz0, dv2, pe2, fe2, bz2;

    int total = 0;
    int bad   = 0;
    int n0 = 0, n2 = 0;
    logic [7:0] hist0 [32];
    logic [7:0] last2;
    logic       pe0_l, fe0_l, pe2_l, fe2_l;

    always #10 clk = ~clk;

    assign rx0 = sel ? 1'b1 : line;
    assign rx2 = sel ? line : 1'b1;

    uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(d0), .data_valid(dv0),
        .parity_err(pe0), .frame_err(fe0), .busy(bz0));

    uart_rx_os #(.CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY_MODE(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .data_out(d2), .data_valid(dv2),
        .parity_err(pe2), .frame_err(fe2), .busy(bz2));

    // Flags are latched on the valid cycle itself, so they must coincide with it.
    always @(negedge clk) begin
        if (dv0) begin
            hist0[n0 % 32] <= d0;
            pe0_l <= pe0;
            fe0_l <= fe0;
            n0    <= n0 + 1;
        end
        if (dv2) begin
            last2 <= d2;
            pe2_l <= pe2;
            fe2_l <= fe2;
            n2    <= n2 + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bits(input logic v, input int n);
        line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par,
                              input logic stop);
        bits(1'b0, BIT);
        for (int i = 0; i < 8; i++) bits(d[i], BIT);
        if (has_par) bits(par, BIT);
        bits(stop, BIT);
    endtask

    int base;

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_data", d0, 8'h00);
        chk("rst_valid", dv0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_ferr", fe0, 0);
        chk("rst_perr", pe0, 0);
        rst = 1'b0;
        bits(1'b1, 2 * BIT);

        // 8N1 0xA5
        base = n0;
        send_frame(8'hA5, 0, 1'b0, 1'b1);
        bits(1'b1, 20);
        chk("a5_count", n0 - base, 1);
        chk("a5_data", hist0[(n0 - 1) % 32], 8'hA5);
        chk("a5_perr", pe0_l, 0);
        chk("a5_ferr", fe0_l, 0);
        chk("a5_busy", bz0, 0);

        // Even parity, 0x37 has odd weight so parity bit should be 1
        sel = 1'b1;
        base = n2;
        send_frame(8'h37, 1, 1'b0, 1'b1);
        bits(1'b1, 20);
        chk("par_bad_count", n2 - base, 1);
        chk("par_bad_data", last2, 8'h37);
        chk("par_bad_perr", pe2_l, 1);
        chk("par_bad_ferr", fe2_l, 0);
        send_frame(8'h37, 1, 1'b1, 1'b1);
        bits(1'b1, 20);
        chk("par_ok_count", n2 - base, 2);
        chk("par_ok_perr", pe2_l, 0);
        sel = 1'b0;
        bits(1'b1, BIT);

        // Start-bit glitch
        base = n0;
        bits(1'b0, 50);
        chk("glitch_busy_hi", bz0, 1);
        bits(1'b0, 50);
        bits(1'b1, BIT);
        chk("glitch_busy_lo", bz0, 0);
        chk("glitch_count", n0 - base, 0);

        // 0x00 with framing error, then held low (break)
        base = n0;
        send_frame(8'h00, 0, 1'b0, 1'b0);
        bits(1'b0, 5 * BIT);
        chk("brk_count", n0 - base, 1);
        chk("brk_data", hist0[(n0 - 1) % 32], 8'h00);
        chk("brk_ferr", fe0_l, 1);
        chk("brk_busy", bz0, 1);
        bits(1'b1, 10);
        chk("brk_exit_busy", bz0, 0);
        bits(1'b1, BIT);
        send_frame(8'h3C, 0, 1'b0, 1'b1);
        bits(1'b1, 20);
        chk("post_brk_count", n0 - base, 2);
        chk("post_brk_data", hist0[(n0 - 1) % 32], 8'h3C);
        chk("post_brk_ferr", fe0_l, 0);
        bits(1'b1, BIT);

        // Back-to-back, no idle gap
        base = n0;
        send_frame(8'h55, 0, 1'b0, 1'b1);
        send_frame(8'hAA, 0, 1'b0, 1'b1);
        bits(1'b1, 20);
        chk("b2b_count", n0 - base, 2);
        chk("b2b_first", hist0[base % 32], 8'h55);
        chk("b2b_second", hist0[(base + 1) % 32], 8'hAA);
        bits(1'b1, BIT);

        // Reset during DATA of 0xFF
        base = n0;
        bits(1'b0, BIT);
        bits(1'b1, 3 * BIT + BIT / 2);
        rst = 1'b1;
        bits(1'b1, 20);
        chk("mid_rst_data", d0, 8'h00);
        chk("mid_rst_busy", bz0, 0);
        chk("mid_rst_valid", dv0, 0);
        rst = 1'b0;
        bits(1'b1, 2 * BIT);
        chk("mid_rst_count", n0 - base, 0);
        send_frame(8'h12, 0, 1'b0, 1'b1);
        bits(1'b1, 20);
        chk("after_rst_count", n0 - base, 1);
        chk("after_rst_data", d0, 8'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
